noc_fifo_arbiter: RTL and testbench
===================================

# noc_fifo_arbiter

Packet-level round-robin arbiter that shares one SizedFifo input port (PipeIn of NOCDataH, 144 bits) among NREQ requesters. A requester wins the FIFO for a whole multi-beat packet: the beat count comes from the `length` field of the packet's head beat. The block sits between NoC source ports and the shared ingress FIFO. It is a zero-latency, combinational pass-through on the data path; the grant, burst and fairness state is sequential.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DATA_W`, 128: NOCDataH `data` width.
- `LEN_W`, 16: NOCDataH `length` width. Beat width `BW` = `DATA_W` + `LEN_W` = 144.
- `CLK`  in  1  single clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `req_pend`  in  NREQ  level per requester: has a beat to offer.
- `req_enq__ENA`  in  NREQ  per-requester enqueue strobe. Legal only while the matching `__RDY` is high.
- `req_enq$v`  in  NREQ*BW  per-requester NOCDataH beat. Slice i is `[i*BW +: BW]`, with `length` in the upper `LEN_W` bits.
- `req_enq__RDY`  out  NREQ  per-requester guard.
- `fifo_enq__ENA`  out  1  enqueue strobe to the SizedFifo.
- `fifo_enq$v`  out  BW  beat to the SizedFifo.
- `fifo_enq__RDY`  in  1  FIFO not full.
- `busy`  out  1  a multi-beat packet is in progress (BURST).
- `grant_id`  out  3  current owner in BURST; in IDLE, the current winner (0 if none).
- `pkt_count`  out  16  completed packets, wraps at 0xFFFF -> 0.

## Operation
- Registered state:
  - `state` ∈ {IDLE, BURST}
  - `owner` (3 b)
  - `remaining` (LEN_W b)
  - `rr_ptr` (3 b)
  - `pkt_count`
- Winner in IDLE:
  - Combinational selection of the first i with `req_pend[i]`=1, scanning `rr_ptr`, `rr_ptr`+1, … mod NREQ.
  - No pending requester: no winner, all RDY low.
- Guards:
  - IDLE: `req_enq__RDY[i]` = `fifo_enq__RDY` & (i == winner).
  - BURST: `req_enq__RDY[i]` = `fifo_enq__RDY` & (i == owner).
  - At most one RDY bit is high at any time.
- Forwarding:
  - `fifo_enq__ENA` = OR over i of (`req_enq__ENA[i]` & `req_enq__RDY[i]`).
  - `fifo_enq$v` = slice of the granted requester, passed unmodified.
  - An ENA without RDY is a protocol violation. It is ignored: not forwarded, no state change.
- Head beat (transfer in IDLE):
  - L = `length` field; L=0 is treated as 1.
  - L=1: stay IDLE, `rr_ptr` <= winner+1 mod NREQ, `pkt_count`++.
  - L>1: state <= BURST, `owner` <= winner, `remaining` <= L-1.
- Body beat (transfer in BURST):
  - `remaining`--. The `length` field of body beats is ignored but forwarded.
  - Transfer with `remaining`==1: state <= IDLE, `rr_ptr` <= owner+1 mod NREQ, `pkt_count`++.
- BURST is never pre-empted. Other requesters' `req_pend` has no effect until the owner's tail beat.
- The owner dropping `req_pend` mid-burst does not release the grant. The arbiter waits indefinitely.

## Timing
- Data latency 0: beat and ENA reach the FIFO in the same cycle as the requester's ENA.
- Throughput is 1 beat/cycle. There is no bubble between packets: a new head may transfer in the cycle after a tail, because IDLE arbitration is combinational.
- `fifo_enq__RDY` low stalls the current owner or winner. State holds and no beat is lost.
- Winner may change cycle to cycle in IDLE as `req_pend` changes. The committed choice is taken only on the head-beat transfer.
- Reset values: `state` IDLE, `owner` 0, `remaining` 0, `rr_ptr` 0, `pkt_count` 0, `busy` 0, `grant_id` 0.
- While `nRST`=0: all `req_enq__RDY` = 0 and `fifo_enq__ENA` = 0.
- Reset asserted mid-burst aborts the packet immediately. Already-enqueued beats stay in the FIFO and no tail is generated.

## Test plan
- Single head-only packet: all 4 pending, L=1 each, FIFO always ready.
  - Grants 0,1,2,3,0 on consecutive cycles.
  - `pkt_count` = 5 after 5 cycles; `busy` never 1.
- Burst lock: req0 sends L=3 while req1 is pending.
  - FIFO receives 3 req0 beats back-to-back, `busy`=1 for beats 2–3.
  - req1's head follows on the very next cycle; `pkt_count` = 2.
- Back-pressure: mid-burst of L=4, `fifo_enq__RDY` low for 2 cycles.
  - `req_enq__RDY[owner]`=0 during the stall and `remaining` holds.
  - Exactly 4 beats enqueued in total, in order.
- L=0 head: treated as a single beat, stay IDLE, `rr_ptr` advances.
- Violation and reset: req2 asserts ENA while not granted → no `fifo_enq__ENA`. Then assert `nRST` low during an L=5 burst after 2 beats.
  - All outputs return to reset values asynchronously.
  - After release, req0 wins first when all are pending.
- Wrap: run 65536 L=1 packets → `pkt_count` returns to 0.

Source files
------------

// File: rtl/noc_fifo_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO enqueue port among NREQ requesters.
// The data path is a combinational pass-through. Grant, burst and fairness state are registered.
module noc_fifo_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16,
  localparam int BW    = DATA_W + LEN_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NREQ-1:0]  req_pend,
  input  logic [NREQ-1:0]  req_enq__ENA,
  input  logic [NREQ*BW-1:0] req_enq_v,
  output logic [NREQ-1:0]  req_enq__RDY,
  output logic             fifo_enq__ENA,
  output logic [BW-1:0]    fifo_enq_v,
  input  logic             fifo_enq__RDY,
  output logic             busy,
  output logic [2:0]       grant_id,
  output logic [15:0]      pkt_count
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             has_winner;
  logic [2:0]       winner;
  logic             gnt_valid;
  logic [2:0]       gnt_id;
  logic [NREQ-1:0]  rdy_raw;
  logic             xfer;
  logic [BW-1:0]    beat;
  logic [LEN_W-1:0] head_len;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(NREQ - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Scan in reverse so the last hit is the first pending requester at or after rr_ptr.
  always_comb begin
    int idx;
    idx        = 0;
    has_winner = 1'b0;
    winner     = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req_pend[idx]) begin
        has_winner = 1'b1;
        winner     = 3'(idx);
      end
    end
  end

  always_comb begin
    gnt_valid = (state_q == BURST) || has_winner;
    gnt_id    = (state_q == BURST) ? owner_q : winner;
    rdy_raw   = '0;
    beat      = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdy_raw[i] = fifo_enq__RDY && gnt_valid && (3'(i) == gnt_id);
      if (3'(i) == gnt_id) begin
        beat = req_enq_v[i*BW +: BW];
      end
    end
    xfer     = |(req_enq__ENA & rdy_raw);
    head_len = beat[BW-1 -: LEN_W];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        // A zero length field still carries one beat.
        if (head_len <= LEN_W'(1)) begin
          rr_ptr_d    = next_ptr(winner);
          pkt_count_d = pkt_count_q + 16'd1;
        end else begin
          state_d     = BURST;
          owner_d     = winner;
          remaining_d = head_len - LEN_W'(1);
        end
      end else begin
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          state_d     = IDLE;
          rr_ptr_d    = next_ptr(owner_q);
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      owner_q     <= 3'd0;
      remaining_q <= '0;
      rr_ptr_q    <= 3'd0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // The winner is combinational from req_pend, so grant outputs are forced quiet during reset.
  assign req_enq__RDY  = nRST ? rdy_raw : '0;
  assign fifo_enq__ENA = nRST && xfer;
  assign fifo_enq_v    = beat;
  assign busy          = (state_q == BURST);
  assign grant_id      = (nRST && gnt_valid) ? gnt_id : 3'd0;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_noc_fifo_arbiter.sv
// Self-checking bench for noc_fifo_arbiter: directed scenarios plus random traffic
// compared against a packet-level reference model.
module tb_noc_fifo_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 16;
  localparam int BW     = DATA_W + LEN_W;

  logic              CLK;
  logic              nRST;
  logic [NREQ-1:0]   req_pend;
  logic [NREQ-1:0]   req_enq__ENA;
  logic [NREQ*BW-1:0] req_enq_v;
  logic [NREQ-1:0]   req_enq__RDY;
  logic              fifo_enq__ENA;
  logic [BW-1:0]     fifo_enq_v;
  logic              fifo_enq__RDY;
  logic              busy;
  logic [2:0]        grant_id;
  logic [15:0]       pkt_count;

  logic [BW-1:0]     beat [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int enq_seen = 0;

  // Reference model: packet owner, beats left in it, fairness pointer, completed count.
  bit m_busy;
  int m_owner;
  int m_left;
  int m_rr;
  int m_cnt;

  noc_fifo_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_pend     (req_pend),
    .req_enq__ENA (req_enq__ENA),
    .req_enq_v    (req_enq_v),
    .req_enq__RDY (req_enq__RDY),
    .fifo_enq__ENA(fifo_enq__ENA),
    .fifo_enq_v   (fifo_enq_v),
    .fifo_enq__RDY(fifo_enq__RDY),
    .busy         (busy),
    .grant_id     (grant_id),
    .pkt_count    (pkt_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always_comb begin
    req_enq_v = '0;
    for (int i = 0; i < NREQ; i++) req_enq_v[i*BW +: BW] = beat[i];
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int len);
    return {LEN_W'(len), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_all_len(input int len);
    for (int i = 0; i < NREQ; i++) beat[i] = mk_beat(len);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_rr = 0; m_cnt = 0;
  endfunction

  function automatic int scan_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (req_pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: evaluate at the falling edge, then let the DUT take the rising edge.
  task automatic cycle(input bit do_check, input int exp_gid);
    int g;
    int len;
    bit xf;
    logic [NREQ-1:0] er;
    @(negedge CLK);
    g  = m_busy ? m_owner : scan_winner();
    er = '0;
    xf = 0;
    if (g >= 0 && fifo_enq__RDY) begin
      er[g] = 1'b1;
      xf    = req_enq__ENA[g];
    end
    if (fifo_enq__ENA) enq_seen++;
    if (do_check) begin
      check("rdy", BW'(req_enq__RDY), BW'(er));
      check("ena", BW'(fifo_enq__ENA), BW'(xf));
      check("busy", BW'(busy), BW'(m_busy));
      check("grant_id", BW'(grant_id), BW'((g < 0) ? 0 : g));
      check("pkt_count", BW'(pkt_count), BW'(m_cnt));
      if (xf) check("data", fifo_enq_v, beat[g]);
    end
    if (exp_gid >= 0) check("grant_seq", BW'(grant_id), BW'(exp_gid));
    if (xf) begin
      if (!m_busy) begin
        len = int'(beat[g][BW-1 -: LEN_W]);
        if (len == 0) len = 1;
        if (len == 1) begin
          m_cnt = (m_cnt + 1) % 65536;
          m_rr  = (g + 1) % NREQ;
        end else begin
          m_busy = 1; m_owner = g; m_left = len - 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % NREQ;
          m_cnt  = (m_cnt + 1) % 65536;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  BW'(req_enq__RDY), '0);
    check({tag, "_ena"},  BW'(fifo_enq__ENA), '0);
    check({tag, "_busy"}, BW'(busy), '0);
    check({tag, "_gid"},  BW'(grant_id), '0);
    check({tag, "_cnt"},  BW'(pkt_count), '0);
  endtask

  // Called just after a rising edge; asserts reset asynchronously mid-cycle.
  task automatic do_reset(input string tag);
    #2 nRST = 1'b0;
    #1 check_reset_outputs(tag);
    req_pend = '1;
    req_enq__ENA = '0;
    @(posedge CLK);
    #1 check_reset_outputs({tag, "_held"});
    #2 nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b1;
    req_pend = '0;
    req_enq__ENA = '1;
    fifo_enq__RDY = 1'b1;
    set_all_len(1);
    model_reset();
    @(posedge CLK);
    #1;
    req_enq__ENA = '1;
    req_pend = '1;
    do_reset("rst0");

    // Head-only packets from all four: strict rotation.
    set_all_len(1);
    req_pend = '1; req_enq__ENA = '1;
    for (int k = 0; k < 5; k++) cycle(1, k % NREQ);
    check("t1_cnt", BW'(pkt_count), BW'(5));

    // Burst lock: req0 holds the port for 3 beats while req1 waits.
    req_pend = 4'b1000; req_enq__ENA = 4'b1000;
    cycle(1, 3);
    beat[0] = mk_beat(3); beat[1] = mk_beat(1);
    req_pend = 4'b0011; req_enq__ENA = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) beat[0] = mk_beat($urandom_range(0, 9));
      cycle(1, (k < 3) ? 0 : 1);
    end
    check("t2_cnt", BW'(pkt_count), BW'(8));

    // Back-pressure in the middle of a 4-beat packet.
    beat[2] = mk_beat(4);
    req_pend = 4'b0100; req_enq__ENA = 4'b0100;
    enq_seen = 0;
    cycle(1, 2);
    beat[2] = mk_beat(7);
    cycle(1, 2);
    fifo_enq__RDY = 1'b0;
    cycle(1, 2);
    cycle(1, 2);
    fifo_enq__RDY = 1'b1;
    beat[2] = mk_beat(0);
    cycle(1, 2);
    cycle(1, 2);
    check("t3_beats", BW'(enq_seen), BW'(4));
    check("t3_idle", BW'(busy), '0);
    check("t3_cnt", BW'(pkt_count), BW'(9));

    // Zero-length head is a single beat and advances the pointer.
    beat[0] = mk_beat(0);
    req_pend = 4'b0001; req_enq__ENA = 4'b0001;
    cycle(1, 0);
    check("t4_busy", BW'(busy), '0);
    check("t4_cnt", BW'(pkt_count), BW'(10));
    set_all_len(1);
    req_pend = '1; req_enq__ENA = '1;
    cycle(1, 1);

    // Ungranted ENA is ignored; then reset in the middle of a 5-beat packet.
    req_pend = 4'b0001; req_enq__ENA = 4'b0100;
    enq_seen = 0;
    cycle(1, 0);
    check("t5_viol", BW'(enq_seen), '0);
    beat[0] = mk_beat(5);
    req_enq__ENA = 4'b0001;
    cycle(1, 0);
    cycle(1, 0);
    check("t5_busy", BW'(busy), BW'(1));
    do_reset("rst1");
    set_all_len(1);
    req_pend = '1; req_enq__ENA = '1;
    cycle(1, 0);
    check("t5_cnt", BW'(pkt_count), BW'(1));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      req_pend = NREQ'($urandom());
      req_enq__ENA = req_pend & NREQ'($urandom() | $urandom());
      if ($urandom_range(0, 15) == 0) req_enq__ENA[$urandom_range(0, NREQ-1)] = 1'b1;
      fifo_enq__RDY = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) beat[i] = mk_beat($urandom_range(0, 4));
      cycle(1, -1);
    end
    fifo_enq__RDY = 1'b1;
    @(posedge CLK);
    #1;

    // Counter wrap after 65536 single-beat packets.
    do_reset("rst2");
    set_all_len(1);
    req_pend = '1; req_enq__ENA = '1;
    for (int n = 0; n < 65536; n++) cycle(0, -1);
    check("wrap_cnt", BW'(pkt_count), '0);
    req_enq__ENA = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
